// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage sitting directly in front of the instruction ROM.
//   Owns the PC, drives the ROM chip-enable and byte address, and captures the
//   combinationally returned instruction into the IF/ID pipeline register.
//   Handles IF/ID stalls, taken-branch redirects from ID and exception flushes.
//
//   Optional feature macro: FETCH_ALIGN_CHK_EN
//     defined   -> an IF/ID load from a PC with non-zero low 3 bits produces a
//                  valid NOP flagged with id_misalign_o for ID to trap on.
//     undefined -> id_misalign_o is tied low and the low PC bits are ignored.
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned          ADDR_W   = 64,
    parameter int unsigned          INST_W   = 64,
    parameter int unsigned          PC_STEP  = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_if,
    input  logic                stall_id,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   new_pc,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_addr_i,
    output logic                rom_ce_o,
    output logic [ADDR_W-1:0]   pc_o,
    input  logic [INST_W-1:0]   inst_i,
    output logic [ADDR_W-1:0]   id_pc_o,
    output logic [INST_W-1:0]   id_inst_o,
    output logic                id_valid_o,
    output logic                id_misalign_o
);

    // Sequential fetch increment, sized to the address bus so the add wraps
    // naturally modulo 2^ADDR_W.
    localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // A fetch address is misaligned when any of the byte-offset bits inside
    // one 64-bit instruction word is set.
    function automatic logic f_is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr[2:0] != 3'b000);
    endfunction

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t              r_state;
    logic                r_ce;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_id_pc;
    logic [INST_W-1:0]   r_id_inst;
    logic                r_id_valid;
    logic                r_id_misalign;

    // ---------------------------------------------------------------------
    // Combinational next-state / next-value wires
    // ---------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_ce_nxt;
    logic                w_active;
    logic                w_branch_take;
    logic                w_misalign;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   w_id_pc_nxt;
    logic [INST_W-1:0]   w_id_inst_nxt;
    logic                w_id_valid_nxt;
    logic                w_id_misalign_nxt;

    // A branch is only honoured when ID is not stalled; ID re-asserts it later.
    assign w_branch_take = branch_flag_i & ~stall_id;

`ifdef FETCH_ALIGN_CHK_EN
    assign w_misalign = f_is_misaligned(r_pc);
`else
    assign w_misalign = 1'b0;
`endif

    // FSM state register with asynchronous reset into the dead IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: IDLE lasts one cycle, HOLD tracks stall_if, flush wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stall_if && !flush) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HOLD: begin
                if (!stall_if || flush) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs: fetch activity of the current state, and the chip-enable
    // value the next state calls for (registered so ce comes off a flop).
    always_comb begin
        w_active = 1'b0;
        w_ce_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_active = 1'b0;
            end
            S_RUN: begin
                w_active = 1'b1;
            end
            S_HOLD: begin
                w_active = 1'b1;
            end
            default: begin
                w_active = 1'b0;
            end
        endcase
        case (w_state_nxt)
            S_RUN:   w_ce_nxt = 1'b1;
            S_HOLD:  w_ce_nxt = 1'b1;
            S_IDLE:  w_ce_nxt = 1'b0;
            default: w_ce_nxt = 1'b0;
        endcase
    end

    // PC selection: flush, then un-stalled branch, then stall hold, then step.
    always_comb begin
        w_pc_nxt = r_pc;
        if (!w_active) begin
            w_pc_nxt = r_pc;
        end else if (flush) begin
            w_pc_nxt = new_pc;
        end else if (w_branch_take) begin
            w_pc_nxt = branch_addr_i;
        end else if (stall_if) begin
            w_pc_nxt = r_pc;
        end else begin
            w_pc_nxt = r_pc + LP_STEP;
        end
    end

    // IF/ID next value: flush bubble, ID-stall hold, squash bubble, or load.
    // The instruction fetched alongside a taken branch is squashed, so a
    // redirect costs exactly one bubble and there is no delay slot.
    always_comb begin
        w_id_pc_nxt       = r_id_pc;
        w_id_inst_nxt     = r_id_inst;
        w_id_valid_nxt    = r_id_valid;
        w_id_misalign_nxt = r_id_misalign;
        if (flush) begin
            w_id_pc_nxt       = {ADDR_W{1'b0}};
            w_id_inst_nxt     = {INST_W{1'b0}};
            w_id_valid_nxt    = 1'b0;
            w_id_misalign_nxt = 1'b0;
        end else if (stall_id) begin
            w_id_pc_nxt       = r_id_pc;
            w_id_inst_nxt     = r_id_inst;
            w_id_valid_nxt    = r_id_valid;
            w_id_misalign_nxt = r_id_misalign;
        end else if (stall_if || w_branch_take || !w_active) begin
            w_id_pc_nxt       = {ADDR_W{1'b0}};
            w_id_inst_nxt     = {INST_W{1'b0}};
            w_id_valid_nxt    = 1'b0;
            w_id_misalign_nxt = 1'b0;
        end else if (w_misalign) begin
            // Deliver a NOP tagged as misaligned; ID raises the exception.
            w_id_pc_nxt       = r_pc;
            w_id_inst_nxt     = {INST_W{1'b0}};
            w_id_valid_nxt    = 1'b1;
            w_id_misalign_nxt = 1'b1;
        end else begin
            w_id_pc_nxt       = r_pc;
            w_id_inst_nxt     = inst_i;
            w_id_valid_nxt    = 1'b1;
            w_id_misalign_nxt = 1'b0;
        end
    end

    // PC and ROM chip-enable registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ce <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            r_ce <= w_ce_nxt;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_pc       <= {ADDR_W{1'b0}};
            r_id_inst     <= {INST_W{1'b0}};
            r_id_valid    <= 1'b0;
            r_id_misalign <= 1'b0;
        end else begin
            r_id_pc       <= w_id_pc_nxt;
            r_id_inst     <= w_id_inst_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_misalign <= w_id_misalign_nxt;
        end
    end

    assign rom_ce_o      = r_ce;
    assign pc_o          = r_pc;
    assign id_pc_o       = r_id_pc;
    assign id_inst_o     = r_id_inst;
    assign id_valid_o    = r_id_valid;
    assign id_misalign_o = r_id_misalign;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed, table-driven bench for if_fetch_stage. A small ROM model returns
//   BASE ^ (addr >> 3) for every address; expected values in the vector table
//   are written out by hand. Hand-written sequences cover asynchronous reset
//   mid-stream and the misaligned-fetch behaviour (macro FETCH_ALIGN_CHK_EN).
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [63:0] ROM_BASE = 64'hC0DE_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [63:0] new_pc;
    logic        branch_flag_i;
    logic [63:0] branch_addr_i;
    logic        rom_ce_o;
    logic [63:0] pc_o;
    logic [63:0] inst_i;
    logic [63:0] id_pc_o;
    logic [63:0] id_inst_o;
    logic        id_valid_o;
    logic        id_misalign_o;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        si;
        logic        sd;
        logic        fl;
        logic [63:0] npc;
        logic        br;
        logic [63:0] badr;
        logic [63:0] e_pc;
        logic        e_ce;
        logic [63:0] e_id_pc;
        logic [63:0] e_id_inst;
        logic        e_valid;
    } vec_t;

    vec_t vecs[19];

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .rom_ce_o      (rom_ce_o),
        .pc_o          (pc_o),
        .inst_i        (inst_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o),
        .id_misalign_o (id_misalign_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational ROM model indexed by the word address.
    always_comb begin
        inst_i = ROM_BASE ^ {3'b000, pc_o[63:3]};
    end

    function automatic vec_t mk(input logic si, input logic sd, input logic fl,
                                input logic [63:0] npc, input logic br,
                                input logic [63:0] badr, input logic [63:0] e_pc,
                                input logic e_ce, input logic [63:0] e_id_pc,
                                input logic [63:0] e_id_inst, input logic e_valid);
        vec_t v;
        v.si = si; v.sd = sd; v.fl = fl; v.npc = npc; v.br = br; v.badr = badr;
        v.e_pc = e_pc; v.e_ce = e_ce; v.e_id_pc = e_id_pc;
        v.e_id_inst = e_id_inst; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] e_pc, input logic e_ce,
                           input logic [63:0] e_id_pc, input logic [63:0] e_id_inst,
                           input logic e_valid, input logic e_mis);
        chk({tag, " pc_o"},          pc_o,                  e_pc);
        chk({tag, " rom_ce_o"},      {63'd0, rom_ce_o},     {63'd0, e_ce});
        chk({tag, " id_pc_o"},       id_pc_o,               e_id_pc);
        chk({tag, " id_inst_o"},     id_inst_o,             e_id_inst);
        chk({tag, " id_valid_o"},    {63'd0, id_valid_o},   {63'd0, e_valid});
        chk({tag, " id_misalign_o"}, {63'd0, id_misalign_o}, {63'd0, e_mis});
    endtask

    task automatic idle_inputs();
        stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0; new_pc = 64'd0;
        branch_flag_i = 1'b0; branch_addr_i = 64'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        mis_en;
        logic [63:0] mis_inst_a;
        logic [63:0] mis_inst_b;
        n_checks = 0;
        n_errors = 0;
`ifdef FETCH_ALIGN_CHK_EN
        mis_en     = 1'b1;
        mis_inst_a = 64'd0;
        mis_inst_b = 64'd0;
`else
        mis_en     = 1'b0;
        mis_inst_a = 64'hC0DE_0000_0000_0005;
        mis_inst_b = 64'hC0DE_0000_0000_0006;
`endif

        //                si    sd    fl    new_pc                  br    br_addr      exp pc                  ce    id_pc                   id_inst                 valid
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd0,                  1'b1, 64'd0,                  64'd0,                  1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd8,                  1'b1, 64'd0,                  64'hC0DE_0000_0000_0000, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd16,                 1'b1, 64'd8,                  64'hC0DE_0000_0000_0001, 1'b1);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd16,                 1'b1, 64'd0,                  64'd0,                  1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd16,                 1'b1, 64'd0,                  64'd0,                  1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd24,                 1'b1, 64'd16,                 64'hC0DE_0000_0000_0002, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b1, 64'd40,   64'd40,                 1'b1, 64'd0,                  64'd0,                  1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd48,                 1'b1, 64'd40,                 64'hC0DE_0000_0000_0005, 1'b1);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd48,                 1'b1, 64'd40,                 64'hC0DE_0000_0000_0005, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd48,                 1'b1, 64'd40,                 64'hC0DE_0000_0000_0005, 1'b1);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 64'd0,                  1'b1, 64'h80,   64'd48,                 1'b1, 64'd40,                 64'hC0DE_0000_0000_0005, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd56,                 1'b1, 64'd48,                 64'hC0DE_0000_0000_0006, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 64'd0,                  1'b1, 64'h80,   64'd64,                 1'b1, 64'd48,                 64'hC0DE_0000_0000_0006, 1'b1);
        vecs[13] = mk(1'b1, 1'b1, 1'b1, 64'h100,                1'b1, 64'h80,   64'h100,                1'b1, 64'd0,                  64'd0,                  1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'h108,                1'b1, 64'h100,                64'hC0DE_0000_0000_0020, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'h110,                1'b1, 64'h108,                64'hC0DE_0000_0000_0021, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'd0,   64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'd0,                 64'd0,                  1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd0,                  1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDF21_FFFF_FFFF_FFFF, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 64'd0,                  1'b0, 64'd0,    64'd8,                  1'b1, 64'd0,                  64'hC0DE_0000_0000_0000, 1'b1);

        // Reset held for three clocks, then released: one dead cycle with ce low.
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_hold", 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_all("reset_release", 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Vector table: stream, stall_if, stall_id, branch, ignored branch,
        // flush+branch+stall, address wrap.
        for (int i = 0; i < 19; i++) begin
            stall_if      = vecs[i].si;
            stall_id      = vecs[i].sd;
            flush         = vecs[i].fl;
            new_pc        = vecs[i].npc;
            branch_flag_i = vecs[i].br;
            branch_addr_i = vecs[i].badr;
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ce, vecs[i].e_id_pc,
                    vecs[i].e_id_inst, vecs[i].e_valid, 1'b0);
        end
        idle_inputs();

        // Asynchronous reset mid-stream takes effect without a clock edge.
        rst = 1'b1;
        #1;
        chk_all("async_rst", 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        chk_all("async_rst_held", 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("restart_c1", 64'd0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        chk_all("restart_c2", 64'd8, 1'b1, 64'd0, 64'hC0DE_0000_0000_0000, 1'b1, 1'b0);

        // Branch to a misaligned target 0x2C and stream two words from it.
        branch_flag_i = 1'b1;
        branch_addr_i = 64'h2C;
        step();
        chk_all("mis_redirect", 64'h2C, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
        idle_inputs();
        step();
        chk_all("mis_load_a", 64'h34, 1'b1, 64'h2C, mis_inst_a, 1'b1, mis_en);
        step();
        chk_all("mis_load_b", 64'h3C, 1'b1, 64'h34, mis_inst_b, 1'b1, mis_en);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
